// File: rtl/systolic_load_scheduler_if.sv
// Handshake, memory-read and lane-push signals shared between the load
// scheduler (slave side) and its environment (master side).
interface systolic_load_scheduler_if #(
  parameter int N      = 5,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_address;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [N-1:0]      fifo_full;
  logic [N-1:0]      lane_push;
  logic [DATA_W-1:0] lane_data;

  modport master (
    output start, base_address, mem_rdata, fifo_full,
    input  busy, done, mem_rd_en, mem_addr, lane_push, lane_data
  );

  modport slave (
    input  start, base_address, mem_rdata, fifo_full,
    output busy, done, mem_rd_en, mem_addr, lane_push, lane_data
  );
endinterface

// File: rtl/systolic_load_scheduler.sv
// Walks an NxN row-major matrix and feeds one row per lane FIFO from a shared memory.
// Define SKEW_EN for diagonal-skewed wavefront order with zero pads; undefined gives plain rows.
//
// state | meaning
// IDLE  | waiting for start, counters cleared
// ISSUE | one (t, i) slot per unstalled cycle
// DRAIN | last issued slot is pushed
// DONE  | one-cycle done pulse
module systolic_load_scheduler #(
  parameter int N      = 5,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  systolic_load_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int CW = $clog2(2 * N);
  localparam int LW = $clog2(N);
`ifdef SKEW_EN
  localparam int T_LAST = 2 * N - 2;
`else
  localparam int T_LAST = N - 1;
`endif

  state_t            state, state_nxt;
  logic [CW-1:0]     t_cnt;
  logic [LW-1:0]     i_cnt;
  logic [ADDR_W-1:0] base_q;
  logic              pipe_vld;
  logic [LW-1:0]     pipe_lane;
  logic              pipe_pad;

  logic              stall;
  logic              slot_real;
  logic              issue;
  logic              last_slot;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] slot_addr;

  // Slot decode: column within the row and whether the slot is a pad.
  always_comb begin
    stall = bus.fifo_full[i_cnt];
`ifdef SKEW_EN
    col       = t_cnt - CW'(i_cnt);
    slot_real = (t_cnt >= CW'(i_cnt)) && (col < CW'(N));
`else
    col       = t_cnt;
    slot_real = 1'b1;
`endif
    issue     = (state == S_ISSUE) && !stall && !rst;
    last_slot = (t_cnt == CW'(T_LAST)) && (i_cnt == LW'(N - 1));
    slot_addr = base_q + ADDR_W'(i_cnt) * ADDR_W'(N) + ADDR_W'(col);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ISSUE;
      S_ISSUE: if (issue && last_slot) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Slot counters (i inner) and the one-deep push pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cnt     <= '0;
      i_cnt     <= '0;
      base_q    <= '0;
      pipe_vld  <= 1'b0;
      pipe_lane <= '0;
      pipe_pad  <= 1'b0;
    end else begin
      pipe_vld  <= issue;
      pipe_lane <= i_cnt;
      pipe_pad  <= !slot_real;
      if (state == S_IDLE) begin
        t_cnt <= '0;
        i_cnt <= '0;
        if (bus.start) base_q <= bus.base_address;
      end else if (issue && !last_slot) begin
        if (i_cnt == LW'(N - 1)) begin
          i_cnt <= '0;
          t_cnt <= t_cnt + CW'(1);
        end else begin
          i_cnt <= i_cnt + LW'(1);
        end
      end
    end
  end

  // Outputs are forced low while reset is asserted, so an in-flight read never pushes.
  always_comb begin
    bus.busy      = !rst && (state == S_ISSUE || state == S_DRAIN);
    bus.done      = !rst && (state == S_DONE);
    bus.mem_rd_en = issue && slot_real;
    bus.mem_addr  = bus.mem_rd_en ? slot_addr : '0;
    bus.lane_push = '0;
    bus.lane_data = '0;
    if (pipe_vld && !rst) begin
      bus.lane_push = N'(1) << pipe_lane;
      if (!pipe_pad) bus.lane_data = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_systolic_load_scheduler.sv
// Directed bench for systolic_load_scheduler: lane contents, done timing, stall,
// mid-load reset and ignored starts, with expectations for either SKEW_EN setting.
module tb_systolic_load_scheduler;
  localparam int N  = 5;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef SKEW_EN
  localparam int W        = 2 * N - 1;
  localparam int DONE_OFS = 2 * N * N - N + 2;
`else
  localparam int W        = N;
  localparam int DONE_OFS = N * N + 2;
`endif

  logic clk;
  logic rst;
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   push_total = 0;
  int   bad_idle   = 0;
  int   bad_onehot = 0;
  int   d;
  logic [DW-1:0] q [N][$];

  systolic_load_scheduler_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  systolic_load_scheduler #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: mem[a] = a, one-cycle read latency.
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= DW'(bus.mem_addr);

  always @(negedge clk) begin
    if (bus.lane_push != '0) begin
      push_total++;
      if ($countones(bus.lane_push) != 1) bad_onehot++;
      for (int l = 0; l < N; l++)
        if (bus.lane_push[l]) q[l].push_back(bus.lane_data);
    end else if (bus.lane_data != '0) begin
      bad_idle++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int lane, input int k, input logic [7:0] base);
    int a;
`ifdef SKEW_EN
    if (k < lane || k >= lane + N) return 32'h0;
    a = int'(base) + lane * N + (k - lane);
`else
    a = int'(base) + lane * N + k;
`endif
    return 32'(a & 255);
  endfunction

  task automatic check_lanes(input logic [7:0] base);
    logic [31:0] got;
    for (int l = 0; l < N; l++) begin
      check($sformatf("lane%0d_len", l), 32'(q[l].size()), 32'(W));
      for (int k = 0; k < W; k++) begin
        got = (k < q[l].size()) ? q[l][k] : 32'hDEAD_BEEF;
        check($sformatf("base%0h_lane%0d_w%0d", base, l, k), got, exp_word(l, k, base));
      end
    end
  endtask

  task automatic run_load(input logic [7:0] base, input int stall_len, input int rst_at,
                          input bit pulse_ignored, output int done_at);
    int c;
    int snap;
    int s;
    for (int l = 0; l < N; l++) q[l].delete();
    done_at = -1;
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.base_address = base;
    s = cyc;
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
      c = cyc - s;
      bus.start        = 1'b0;
      bus.base_address = 8'h80;
      bus.fifo_full    = '0;
      if (c >= 3 && c < 3 + stall_len) bus.fifo_full = 5'b00100;
      if (pulse_ignored && c == 10) bus.start = 1'b1;
      if (c == rst_at) begin
        snap = push_total;
        rst  = 1'b1;
      end
      #1;
      if (c == 3 && stall_len > 0) check("stall_busy", 32'(bus.busy), 32'd1);
      if (c >= 3 && c < 3 + stall_len) check($sformatf("stall_rd_en_c%0d", c), 32'(bus.mem_rd_en), 32'd0);
      if (c == rst_at) begin
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_lane_push", 32'(bus.lane_push), 32'd0);
        check("rst_lane_data", bus.lane_data,      32'd0);
        repeat (5) @(posedge clk);
        #2;
        check("rst_no_more_push", 32'(push_total), 32'(snap));
        check("rst_stays_idle",   32'(bus.busy),   32'd0);
        done_at = -2;
        return;
      end
      if (bus.done) begin
        done_at = c;
        if (pulse_ignored) begin
          bus.start        = 1'b1;
          bus.base_address = 8'h80;
        end
        break;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    #1;
    check("done_pulse_width", 32'(bus.done), 32'd0);
    check("busy_after_done",  32'(bus.busy), 32'd0);
    @(posedge clk); #2;
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.base_address = '0;
    bus.fifo_full    = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_done",      32'(bus.done),      32'd0);
    check("reset_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("reset_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("reset_lane_push", 32'(bus.lane_push), 32'd0);
    check("reset_lane_data", bus.lane_data,      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("idle_busy", 32'(bus.busy), 32'd0);

    run_load(8'h10, 0, -1, 1'b1, d);
    check("done_cycle_base10", 32'(d), 32'(DONE_OFS));
    check_lanes(8'h10);

    run_load(8'hF0, 0, -1, 1'b0, d);
    check("done_cycle_wrap", 32'(d), 32'(DONE_OFS));
    check_lanes(8'hF0);

    run_load(8'h00, 3, -1, 1'b0, d);
    check("done_cycle_stall", 32'(d), 32'(DONE_OFS + 3));
    check_lanes(8'h00);

    run_load(8'h40, 0, 20, 1'b0, d);

    run_load(8'h00, 0, -1, 1'b0, d);
    check("done_cycle_after_rst", 32'(d), 32'(DONE_OFS));
    check_lanes(8'h00);

    check("idle_data_nonzero", 32'(bad_idle),   32'd0);
    check("push_not_onehot",   32'(bad_onehot), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
